// File: rtl/ahb_mtimer.sv
// ahb_mtimer: AHB-lite machine timer with 64-bit mtime/mtimecmp and level irq; define MTIMER_PRESCALE_EN to add the PRESC tick prescaler
module ahb_mtimer #(
  parameter int          ADDR_W       = 8,
  parameter logic [63:0] MTIME_RST    = 64'h0,
  parameter logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hsel,
  input  logic [ADDR_W-1:0] haddr,
  input  logic [1:0]        htrans,
  input  logic              hwrite,
  input  logic [2:0]        hsize,
  input  logic [31:0]       hwdata,
  input  logic              hready,
  output logic [31:0]       hrdata,
  output logic              hready_out,
  output logic [1:0]        hresp,
  output logic              timer_irq
);
  logic [63:0] mtime_q, mtime_d, mtime_w, mtimecmp_q, mtimecmp_d;
  logic [31:0] hi_shadow_q, hi_shadow_d, hrdata_q, hrdata_d, presc_rd;
  logic        en_q, en_d, irq_q, irq_d, wr_q, wr_d, ok_q, ok_d;
  logic [2:0]  off_q, off_d, roff;
  logic [7:0]  wsel;
  logic        acc, rd, tick, unused_ok;
  assign acc  = hsel & htrans[1] & hready;
  assign rd   = acc & ~hwrite;
  assign roff = haddr[4:2];
  assign wsel = (wr_q & ok_q) ? 8'(1) << off_q : 8'd0;
`ifdef MTIMER_PRESCALE_EN
  logic [15:0] presc_q, presc_d, pcnt_q, pcnt_d;
  // Prescaler: one tick every PRESC+1 clocks, period restarts when disabled or PRESC is rewritten
  always_comb begin
    presc_d = wsel[5] ? hwdata[15:0] : presc_q;
    tick    = en_q & ~wsel[5] & (pcnt_q == presc_q);
    pcnt_d  = (~en_q | wsel[5] | tick) ? 16'd0 : pcnt_q + 16'd1;
  end
  // Prescaler state
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      pcnt_q  <= '0;
    end else begin
      presc_q <= presc_d;
      pcnt_q  <= pcnt_d;
    end
  end
  assign presc_rd  = {16'd0, presc_d};
  assign unused_ok = &{1'b0, haddr[1:0], haddr[ADDR_W-1:5], htrans[0], wsel[7:6]};
`else
  assign tick      = en_q;
  assign presc_rd  = 32'd0;
  assign unused_ok = &{1'b0, haddr[1:0], haddr[ADDR_W-1:5], htrans[0], wsel[7:5]};
`endif
  // Data-phase write, tick (dropped when software writes mtime), irq compare and read mux over post-write values
  always_comb begin
    mtime_w     = {wsel[1] ? hwdata : mtime_q[63:32], wsel[0] ? hwdata : mtime_q[31:0]};
    mtimecmp_d  = {wsel[3] ? hwdata : mtimecmp_q[63:32], wsel[2] ? hwdata : mtimecmp_q[31:0]};
    en_d        = wsel[4] ? hwdata[0] : en_q;
    mtime_d     = (wsel[0] | wsel[1] | ~tick) ? mtime_w : mtime_q + 64'd1;
    irq_d       = mtime_q >= mtimecmp_q;
    wr_d        = acc & hwrite;
    off_d       = roff;
    ok_d        = hsize == 3'b010;
    hi_shadow_d = (rd && roff == 3'd0) ? mtime_w[63:32] : hi_shadow_q;
    hrdata_d    = ~rd            ? hrdata_q :
                  roff == 3'd0   ? mtime_w[31:0] :
                  roff == 3'd1   ? (wsel[1] ? hwdata : hi_shadow_q) :
                  roff == 3'd2   ? mtimecmp_d[31:0] :
                  roff == 3'd3   ? mtimecmp_d[63:32] :
                  roff == 3'd4   ? {31'd0, en_d} :
                  roff == 3'd5   ? presc_rd : 32'd0;
  end
  // Timer registers and pending data-phase state; reset discards any pending write
  always_ff @(posedge clk) begin
    if (rst) begin
      mtime_q     <= MTIME_RST;
      mtimecmp_q  <= MTIMECMP_RST;
      en_q        <= 1'b0;
      irq_q       <= 1'b0;
      wr_q        <= 1'b0;
      ok_q        <= 1'b0;
      off_q       <= 3'd0;
      hi_shadow_q <= 32'd0;
      hrdata_q    <= 32'd0;
    end else begin
      mtime_q     <= mtime_d;
      mtimecmp_q  <= mtimecmp_d;
      en_q        <= en_d;
      irq_q       <= irq_d;
      wr_q        <= wr_d;
      ok_q        <= ok_d;
      off_q       <= off_d;
      hi_shadow_q <= hi_shadow_d;
      hrdata_q    <= hrdata_d;
    end
  end
  assign hrdata     = hrdata_q;
  assign timer_irq  = irq_q;
  assign hready_out = 1'b1;
  assign hresp      = 2'b00;
endmodule

// File: tb/tb_ahb_mtimer.sv
// tb_ahb_mtimer: randomized and directed bench for ahb_mtimer against a transaction-level reference model
module tb_ahb_mtimer;
  logic        clk = 1'b0, rst = 1'b1, hsel = 1'b0, hwrite = 1'b0, hready = 1'b1;
  logic [7:0]  haddr = 8'd0;
  logic [1:0]  htrans = 2'b00;
  logic [2:0]  hsize = 3'd2;
  logic [31:0] hwdata = 32'd0, nxt_wd = 32'd0;
  logic [31:0] hrdata;
  logic        hready_out, timer_irq;
  logic [1:0]  hresp;
  int          n_cmp = 0, n_err = 0;
  logic [63:0] m_mt, m_cmp;
  logic        m_en, m_irq, m_pw, m_pok;
  logic [31:0] m_sh, m_rd;
  logic [2:0]  m_pa;
`ifdef MTIMER_PRESCALE_EN
  logic [15:0] m_presc;
  int          m_age;
`endif
  logic [31:0] a, b;
  ahb_mtimer dut (
    .clk(clk), .rst(rst), .hsel(hsel), .haddr(haddr), .htrans(htrans), .hwrite(hwrite),
    .hsize(hsize), .hwdata(hwdata), .hready(hready), .hrdata(hrdata), .hready_out(hready_out),
    .hresp(hresp), .timer_irq(timer_irq)
  );
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // Reference model: next register image from the current bus inputs and the previous cycle's accepted write
  task automatic model_step();
    logic [63:0] mt, cmp;
    logic        en, wr, mtw, prw, tick;
    logic [2:0]  off;
`ifdef MTIMER_PRESCALE_EN
    logic [15:0] pr;
`endif
    if (rst) begin
      m_mt = 64'h0; m_cmp = 64'hFFFF_FFFF_FFFF_FFFF; m_en = 1'b0; m_sh = 32'd0; m_rd = 32'd0;
      m_irq = 1'b0; m_pw = 1'b0; m_pok = 1'b0; m_pa = 3'd0;
`ifdef MTIMER_PRESCALE_EN
      m_presc = 16'd0; m_age = 0;
`endif
      return;
    end
    mt = m_mt; cmp = m_cmp; en = m_en; mtw = 1'b0; prw = 1'b0;
`ifdef MTIMER_PRESCALE_EN
    pr = m_presc;
`endif
    wr = m_pw && m_pok;
    if (wr) begin
      case (m_pa)
        3'd0: begin mt[31:0] = hwdata; mtw = 1'b1; end
        3'd1: begin mt[63:32] = hwdata; mtw = 1'b1; end
        3'd2: cmp[31:0] = hwdata;
        3'd3: cmp[63:32] = hwdata;
        3'd4: en = hwdata[0];
`ifdef MTIMER_PRESCALE_EN
        3'd5: begin pr = hwdata[15:0]; prw = 1'b1; end
`endif
        default: ;
      endcase
    end
`ifdef MTIMER_PRESCALE_EN
    tick  = m_en && !prw && (m_age % (int'(m_presc) + 1)) == int'(m_presc);
    m_age = (m_en && !prw) ? m_age + 1 : 0;
`else
    tick = m_en;
`endif
    if (hsel && htrans[1] && hready && !hwrite) begin
      off = haddr[4:2];
      case (off)
        3'd0: m_rd = mt[31:0];
        3'd1: m_rd = (wr && m_pa == 3'd1) ? hwdata : m_sh;
        3'd2: m_rd = cmp[31:0];
        3'd3: m_rd = cmp[63:32];
        3'd4: m_rd = {31'd0, en};
`ifdef MTIMER_PRESCALE_EN
        3'd5: m_rd = {16'd0, pr};
`endif
        default: m_rd = 32'd0;
      endcase
      if (off == 3'd0) m_sh = mt[63:32];
    end
    m_irq = m_mt >= m_cmp;
    m_mt  = (tick && !mtw) ? mt + 64'd1 : mt;
    m_cmp = cmp;
    m_en  = en;
`ifdef MTIMER_PRESCALE_EN
    m_presc = pr;
`endif
    m_pw  = hsel && htrans[1] && hready && hwrite;
    m_pa  = haddr[4:2];
    m_pok = hsize == 3'b010;
  endtask
  task automatic xfer(input logic sel, input logic [1:0] tr, input logic wr, input logic [2:0] off,
                      input logic [2:0] sz, input logic [31:0] wd);
    hsel = sel; htrans = tr; hwrite = wr; hsize = sz;
    haddr = {3'($urandom_range(0, 7)), off, 2'b00};
    hwdata = nxt_wd;
    nxt_wd = wd;
    model_step();
    @(posedge clk);
    #1;
    check("hrdata", hrdata, m_rd);
    check("timer_irq", timer_irq, m_irq);
    check("hready_out", hready_out, 1);
    check("hresp", hresp, 0);
  endtask
  task automatic idle();
    xfer(1'b0, 2'b00, 1'b0, 3'd0, 3'd2, $urandom);
  endtask
  task automatic bus_wr(input logic [2:0] off, input logic [31:0] d);
    xfer(1'b1, 2'b10, 1'b1, off, 3'd2, d);
  endtask
  task automatic bus_rd(input logic [2:0] off);
    xfer(1'b1, 2'b10, 1'b0, off, 3'd2, $urandom);
  endtask
  initial begin
    rst = 1'b1;
    idle();
    idle();
    rst = 1'b0;
    bus_rd(3'd4); check("rst_ctrl", hrdata, 0);
    bus_rd(3'd0); check("rst_mtime_lo", hrdata, 0);
    bus_rd(3'd3); check("rst_cmp_hi", hrdata, 32'hFFFF_FFFF);
    check("rst_irq", timer_irq, 0);
    bus_wr(3'd3, 32'd0);
    bus_wr(3'd2, 32'd20);
    bus_wr(3'd4, 32'd1);
    for (int k = 0; k < 100 && !timer_irq; k++) idle();
    check("irq_rise", timer_irq, 1);
    bus_rd(3'd0); check("mtime_at_irq", hrdata, 21);
    bus_wr(3'd2, 32'd1000);
    idle(); check("irq_hold", timer_irq, 1);
    idle(); check("irq_fall", timer_irq, 0);
    bus_wr(3'd4, 32'd0);
    bus_wr(3'd4, 32'd1);
    bus_rd(3'd4); check("raw_ctrl", hrdata, 1);
    bus_wr(3'd0, 32'h100);
    bus_rd(3'd0); check("raw_mtime_lo", hrdata, 32'h100);
    bus_rd(3'd0); check("collision_no_inc", hrdata, 32'h100);
`ifndef MTIMER_PRESCALE_EN
    bus_rd(3'd0); check("collision_next", hrdata, 32'h101);
`endif
    bus_wr(3'd4, 32'd0);
    bus_wr(3'd1, 32'd0);
    bus_wr(3'd0, 32'hFFFF_FFFE);
    bus_wr(3'd4, 32'd1);
    for (int r = 0; r < 3; r++) begin
      bus_rd(3'd0); a = hrdata;
      for (int k = 0; k < 4; k++) idle();
      bus_rd(3'd1);
      check("atomic_hi", hrdata, (a >= 32'hFFFF_FFFE) ? 0 : 1);
    end
    bus_wr(3'd4, 32'd0);
    xfer(1'b1, 2'b10, 1'b1, 3'd2, 3'd0, 32'hAB);
    idle();
    bus_rd(3'd2); check("byte_write_ignored", hrdata, 1000);
    xfer(1'b0, 2'b10, 1'b1, 3'd2, 3'd2, 32'h55);
    idle();
    bus_rd(3'd2); check("hsel0_ignored", hrdata, 1000);
    xfer(1'b1, 2'b00, 1'b1, 3'd2, 3'd2, 32'h77);
    idle();
    bus_rd(3'd2); check("idle_ignored", hrdata, 1000);
    bus_rd(3'd6); check("undef_0x18", hrdata, 0);
`ifndef MTIMER_PRESCALE_EN
    bus_wr(3'd5, 32'd7);
    bus_rd(3'd5); check("undef_0x14", hrdata, 0);
`endif
    bus_wr(3'd2, 32'd5);
    rst = 1'b1;
    idle();
    rst = 1'b0;
    check("hrdata_after_rst", hrdata, 0);
    bus_rd(3'd2); check("rst_drops_write", hrdata, 32'hFFFF_FFFF);
`ifdef MTIMER_PRESCALE_EN
    bus_wr(3'd5, 32'd3);
    bus_wr(3'd4, 32'd1);
    idle();
    bus_rd(3'd0); a = hrdata;
    for (int k = 0; k < 39; k++) idle();
    bus_rd(3'd0); b = hrdata;
    check("presc_rate", b - a, 10);
    bus_rd(3'd5); check("presc_readback", hrdata, 3);
    idle();
    bus_wr(3'd5, 32'd3);
    for (int k = 0; k < 9; k++) bus_rd(3'd0);
`else
    bus_wr(3'd4, 32'd1);
    idle();
    bus_rd(3'd0); a = hrdata;
    for (int k = 0; k < 39; k++) idle();
    bus_rd(3'd0); b = hrdata;
    check("tick_rate", b - a, 40);
`endif
    for (int i = 0; i < 1500; i++) begin
      logic [2:0]  off;
      logic [31:0] d;
      rst    = ($urandom_range(0, 99) == 0);
      hready = ($urandom_range(0, 9) != 0);
      off    = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      d      = ($urandom_range(0, 1) == 1) ? $urandom : $urandom_range(0, 40);
      xfer($urandom_range(0, 7) != 0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), off,
           ($urandom_range(0, 5) == 0) ? 3'($urandom_range(0, 3)) : 3'd2, d);
    end
    rst = 1'b0;
    hready = 1'b1;
    idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/ahb_mtimer.md
Name: ahb_mtimer

Overview:
- Memory-mapped machine timer on the core data-side AHB-lite bus.
- Holds a 64-bit free-running mtime counter and a 64-bit mtimecmp compare register.
- Drives the level interrupt request that feeds the core's timer input into interrupt_ctrl.
- Zero-wait-state slave: never stalls d_hready and never returns an error.

Parameters:
- ADDR_W, 8: number of haddr bits decoded; register offsets use haddr[4:2].
- MTIME_RST, 0: 64-bit reset value of mtime.
- MTIMECMP_RST, 64'hFFFF_FFFF_FFFF_FFFF: reset value of mtimecmp, so no interrupt fires after reset.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous, active-high reset.
- hsel  in  1  slave select from the data-bus decoder.
- haddr  in  ADDR_W  byte address.
- htrans  in  2  AHB transfer type.
- hwrite  in  1  1 = write.
- hsize  in  3  transfer size.
- hwdata  in  32  write data, valid in the data phase.
- hready  in  1  bus ready; an address phase is accepted only when this is 1.
- hrdata  out  32  read data.
- hready_out  out  1  slave ready.
- hresp  out  2  response.
- timer_irq  out  1  level timer interrupt request.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - mtime = MTIME_RST; mtimecmp = MTIMECMP_RST.
  - ctrl = 0 (counter stopped); hi_shadow = 0.
  - hrdata = 0; timer_irq = 0; all data-phase registers cleared.
  - hready_out is tied to 1 and hresp is tied to 2'b00 at all times, including during reset.
- Register map (word offset):
  - 0x00 MTIME_LO (rw)
  - 0x04 MTIME_HI (rw)
  - 0x08 MTIMECMP_LO (rw)
  - 0x0C MTIMECMP_HI (rw)
  - 0x10 CTRL (rw): bit0 EN, bits[31:1] read 0.
  - 0x14 PRESC (rw; see Optional Feature).
  - Any other offset: read 0, write ignored.
- Address phase, accepted when hsel & htrans[1] & hready:
  - Register haddr[4:2], hwrite, and size_ok = (hsize==3'b010).
  - For reads, hrdata is loaded at this same edge. Read data is therefore valid throughout the following data phase, i.e. a 1-cycle read latency aligned to AHB.
- Data phase: a pending write with size_ok = 1 updates the selected register from hwdata at the end of the data phase. Writes with size_ok = 0 are dropped silently.
- Counter:
  - When EN = 1, mtime increments by 1 per tick, with 64-bit wrap from FFFF_FFFF_FFFF_FFFF to 0.
  - A tick is every clk without the optional feature.
  - When EN = 0, mtime holds.
  - A software write to MTIME_LO or MTIME_HI in the same cycle as a tick: the written half takes hwdata, the other half keeps its pre-increment value, and the increment is lost that cycle.
- Atomic 64-bit read:
  - A read of MTIME_LO captures mtime[63:32] into hi_shadow at the same edge.
  - A read of MTIME_HI returns hi_shadow, not live mtime.
  - MTIMECMP_HI reads live.
- Read-after-write forwarding:
  - Case: an address-phase read coincides with the data phase of a write to the same offset.
  - Required: hrdata returns the new hwdata value, not the stale one.
  - For MTIME_LO, hi_shadow then captures the post-write mtime[63:32].
- Interrupt:
  - timer_irq is registered: timer_irq <= (mtime >= mtimecmp), unsigned 64-bit compare, evaluated every cycle regardless of EN.
  - Latency is 1 clk after the condition becomes true or false.
  - Writing a larger mtimecmp deasserts timer_irq one clk after the write completes.
- Reset mid-transfer: any pending data phase is discarded and the write does not occur. hrdata = 0 in the cycle after reset.
- Back-to-back transfers (every cycle) are fully supported, with no bubbles.

Optional Feature:
- Macro: MTIMER_PRESCALE_EN.
- Defined:
  - Adds a 16-bit PRESC register (reset 0) and a 16-bit prescale counter.
  - A tick occurs when the prescale counter equals PRESC; the counter then returns to 0, giving a period of PRESC+1 clk.
  - The prescale counter resets to 0 whenever EN = 0 or PRESC is written.
  - PRESC reads back with bits[31:16] = 0.
- Not defined:
  - Tick every clk.
  - Offset 0x14 behaves as an undefined offset: read 0, write ignored.
  - No prescale logic is instantiated.

Test Plan:
- Reset then idle:
  - Apply rst for 2 clk, then read CTRL, MTIME_LO, MTIMECMP_HI.
  - Expect 0, 0, FFFF_FFFF; timer_irq = 0; hready_out = 1 throughout.
- Count and compare:
  - Write MTIMECMP_HI = 0, MTIMECMP_LO = 20, CTRL = 1.
  - Expect timer_irq to rise exactly 1 clk after mtime reaches 20.
  - Then write MTIMECMP_LO = 1000; expect timer_irq = 0 one clk after that write's data phase.
- Carry and atomic read:
  - Write MTIME_HI = 0, MTIME_LO = FFFF_FFFE, then CTRL = 1.
  - Read MTIME_LO, then MTIME_HI 5 clk later.
  - The HI value must match the value captured with LO (0 if LO read ≤ FFFF_FFFF before wrap, 1 if after).
  - Never a torn pair.
- Back-to-back RAW and write/tick collision:
  - Write CTRL = 1 immediately followed by a read of CTRL; expect 1.
  - With EN = 1 running, write MTIME_LO = 0x100; the next read returns 0x100 + elapsed ticks, with no +1 double count.
- Illegal accesses:
  - Byte write (hsize = 0) of 0xAB to MTIMECMP_LO: register unchanged.
  - Read of offset 0x18: 0.
  - Transfer with hsel = 0 or htrans = IDLE: no state change.
- Prescaler (with MTIMER_PRESCALE_EN):
  - PRESC = 3, EN = 1.
  - Expect mtime to increase by exactly 1 every 4 clk over 40 clk (10 counts).
  - Rewriting PRESC mid-period restarts the period.
